jk_sync_counter: RTL and testbench



---
 rtl/jk_pkg.sv | 25 ++
 rtl/jk_cell.sv | 45 ++++
 rtl/jk_sync_counter.sv | 107 ++++++++++
 tb/tb_jk_sync_counter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for JK-cell based counters and shift stages:
// direction constants and the carry look-ahead toggle-vector function.
package jk_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  localparam int JK_MAX_W = 16;

  // T[0] follows EN; every higher bit toggles only when all lower bits are
  // at the direction's terminal value (ones going up, zeros going down).
  function automatic logic [JK_MAX_W-1:0] calc_toggle(
    input logic [JK_MAX_W-1:0] q,
    input logic                up,
    input logic                en
  );
    logic [JK_MAX_W-1:0] t;
    t[0] = en;
    for (int i = 1; i < JK_MAX_W; i++) begin
      t[i] = t[i-1] & ((up == CNT_UP) ? q[i-1] : ~q[i-1]);
    end
    return t;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK master-slave style bit with synchronous preset and parallel load.
// Priority per edge: PRE > LD > J/K (00 hold, 01 reset, 10 set, 11 toggle).
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic PRE,
  input  logic PRE_VAL,
  input  logic LD,
  input  logic LD_VAL,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic QBAR
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (LD) begin
      q_d = LD_VAL;
    end else begin
      unique case ({J, K})
        2'b00:   q_d = q_q;
        2'b01:   q_d = 1'b0;
        2'b10:   q_d = 1'b1;
        default: q_d = ~q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (PRE) begin
      q_q <= PRE_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q    = q_q;
  assign QBAR = ~q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Synchronous up/down counter of WIDTH JK cells with look-ahead toggle gating.
// Optional modulo-N counting is enabled by defining JK_CNT_MODN_EN.
module jk_sync_counter
  import jk_pkg::*;
#(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] PRESET_VAL = '0
`ifdef JK_CNT_MODN_EN
  ,
  parameter int               MODULUS    = 10
`endif
) (
  input  logic             clk,
  input  logic             PRE,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QBAR,
  output logic             TC,
  output logic             RCO,
  output logic             OVF
);

  logic [WIDTH-1:0]    q_vec;
  logic [WIDTH-1:0]    qbar_vec;
  logic [JK_MAX_W-1:0] q_ext;
  logic [JK_MAX_W-1:0] t_full;
  logic [WIDTH-1:0]    t_vec;
  logic                cell_ld;
  logic [WIDTH-1:0]    cell_ld_val;
  logic                wrap;
  logic                ovf_q;
  logic                ovf_d;

  always_comb begin
    q_ext             = '0;
    q_ext[WIDTH-1:0]  = q_vec;
    t_full            = calc_toggle(q_ext, UP, EN);
    t_vec             = t_full[WIDTH-1:0];
  end

`ifdef JK_CNT_MODN_EN
  localparam logic [WIDTH-1:0] MOD_MAX = WIDTH'(MODULUS - 1);

  logic mod_up_wrap;
  logic mod_dn_wrap;

  // Modulo wraps reuse the cells' load path; values above MOD_MAX count in
  // plain binary until the natural all-ones rollover.
  always_comb begin
    mod_up_wrap = EN & (UP == CNT_UP) & (q_vec == MOD_MAX);
    mod_dn_wrap = EN & (UP == CNT_DN) & (q_vec == '0);
    TC          = (UP == CNT_UP) ? (q_vec == MOD_MAX) : (q_vec == '0);
    cell_ld     = LOAD | mod_up_wrap | mod_dn_wrap;
    cell_ld_val = D;
    if (!LOAD) begin
      cell_ld_val = mod_dn_wrap ? MOD_MAX : '0;
    end
    wrap = (TC & EN) | (EN & (UP == CNT_UP) & (&q_vec));
  end
`else
  always_comb begin
    TC          = (UP == CNT_UP) ? (&q_vec) : ~(|q_vec);
    cell_ld     = LOAD;
    cell_ld_val = D;
    wrap        = TC & EN;
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell u_cell (
        .clk     (clk),
        .PRE     (PRE),
        .PRE_VAL (PRESET_VAL[gi]),
        .LD      (cell_ld),
        .LD_VAL  (cell_ld_val[gi]),
        .J       (t_vec[gi]),
        .K       (t_vec[gi]),
        .Q       (q_vec[gi]),
        .QBAR    (qbar_vec[gi])
      );
    end
  endgenerate

  // A user LOAD pre-empts counting, so it can never cause a wrap.
  always_comb begin
    ovf_d = ovf_q | (wrap & ~LOAD);
  end

  always_ff @(posedge clk) begin
    if (PRE) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign Q    = q_vec;
  assign QBAR = qbar_vec;
  assign RCO  = TC & EN;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed self-checking bench for jk_sync_counter (WIDTH=4, PRESET_VAL=0).
// Inputs change 1ns after a rising edge; outputs are checked at the same point.
module tb_jk_sync_counter;

  localparam int W = 4;

  logic         clk;
  logic         PRE;
  logic         EN;
  logic         UP;
  logic         LOAD;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic [W-1:0] QBAR;
  logic         TC;
  logic         RCO;
  logic         OVF;

  int n_checks;
  int n_fail;

  jk_sync_counter #(.WIDTH(W), .PRESET_VAL(4'd0)) dut (
    .clk  (clk),
    .PRE  (PRE),
    .EN   (EN),
    .UP   (UP),
    .LOAD (LOAD),
    .D    (D),
    .Q    (Q),
    .QBAR (QBAR),
    .TC   (TC),
    .RCO  (RCO),
    .OVF  (OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    PRE = 1'b1; EN = 1'b0; UP = 1'b1; LOAD = 1'b0; D = '0;
    step();
    step();
    n_checks++;
    if (Q !== 4'd0) begin n_fail++; $display("FAIL reset_q actual=%0d required=0", Q); end
    n_checks++;
    if (QBAR !== 4'hF) begin n_fail++; $display("FAIL reset_qbar actual=%h required=f", QBAR); end
    n_checks++;
    if (OVF !== 1'b0) begin n_fail++; $display("FAIL reset_ovf actual=%b required=0", OVF); end
    n_checks++;
    if (TC !== 1'b0 || RCO !== 1'b0) begin
      n_fail++; $display("FAIL reset_tc_rco actual=%b%b required=00", TC, RCO);
    end
  endtask

  task automatic test_up_count();
    logic [W-1:0] exp_q;
    PRE = 1'b0; EN = 1'b1; UP = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_q = W'(k % 16);
      n_checks++;
      if (Q !== exp_q) begin n_fail++; $display("FAIL up_q step=%0d actual=%0d required=%0d", k, Q, exp_q); end
      n_checks++;
      if (TC !== (exp_q == 4'd15)) begin
        n_fail++; $display("FAIL up_tc step=%0d actual=%b required=%b", k, TC, (exp_q == 4'd15));
      end
      n_checks++;
      if (OVF !== (k == 16)) begin
        n_fail++; $display("FAIL up_ovf step=%0d actual=%b required=%b", k, OVF, (k == 16));
      end
    end
  endtask

  task automatic test_down_count();
    PRE = 1'b1; EN = 1'b0;
    step();
    PRE = 1'b0; EN = 1'b1; UP = 1'b0;
    #1;
    n_checks++;
    if (RCO !== 1'b1 || TC !== 1'b1) begin
      n_fail++; $display("FAIL down_rco_at_zero actual=%b%b required=11", TC, RCO);
    end
    step();
    n_checks++;
    if (Q !== 4'd15) begin n_fail++; $display("FAIL down_wrap_q actual=%0d required=15", Q); end
    n_checks++;
    if (OVF !== 1'b1 || RCO !== 1'b0) begin
      n_fail++; $display("FAIL down_wrap_flags actual=ovf%b rco%b required=ovf1 rco0", OVF, RCO);
    end
    step();
    n_checks++;
    if (Q !== 4'd14) begin n_fail++; $display("FAIL down_q14 actual=%0d required=14", Q); end
    step();
    n_checks++;
    if (Q !== 4'd13) begin n_fail++; $display("FAIL down_q13 actual=%0d required=13", Q); end
  endtask

  task automatic test_load_priority();
    LOAD = 1'b1; D = 4'b1010; EN = 1'b1; UP = 1'b1;
    step();
    n_checks++;
    if (Q !== 4'd10) begin n_fail++; $display("FAIL load_over_en actual=%0d required=10", Q); end
    n_checks++;
    if (OVF !== 1'b1) begin n_fail++; $display("FAIL load_keeps_ovf actual=%b required=1", OVF); end
    LOAD = 1'b0;
    step();
    n_checks++;
    if (Q !== 4'd11) begin n_fail++; $display("FAIL load_then_count actual=%0d required=11", Q); end
  endtask

  task automatic test_hold();
    LOAD = 1'b1; D = 4'd7; EN = 1'b0;
    step();
    LOAD = 1'b0;
    for (int k = 0; k < 5; k++) begin
      UP = ~UP;
      step();
      n_checks++;
      if (Q !== 4'd7 || QBAR !== 4'd8) begin
        n_fail++; $display("FAIL hold step=%0d actual=q%0d qbar%0d required=q7 qbar8", k, Q, QBAR);
      end
    end
  endtask

  task automatic test_pre_priority();
    PRE = 1'b1;
    step();
    PRE = 1'b0; EN = 1'b1; UP = 1'b1;
    for (int k = 0; k < 12; k++) step();
    n_checks++;
    if (Q !== 4'd12) begin n_fail++; $display("FAIL pre_setup actual=%0d required=12", Q); end
    // Force a sticky flag first so the preset clear is observable.
    LOAD = 1'b1; D = 4'd15;
    step();
    LOAD = 1'b0;
    step();
    n_checks++;
    if (OVF !== 1'b1 || Q !== 4'd0) begin
      n_fail++; $display("FAIL pre_ovf_setup actual=q%0d ovf%b required=q0 ovf1", Q, OVF);
    end
    PRE = 1'b1; LOAD = 1'b1; D = 4'd3;
    step();
    n_checks++;
    if (Q !== 4'd0 || OVF !== 1'b0) begin
      n_fail++; $display("FAIL pre_over_load actual=q%0d ovf%b required=q0 ovf0", Q, OVF);
    end
    PRE = 1'b0; LOAD = 1'b0; EN = 1'b1;
    step();
    n_checks++;
    if (Q !== 4'd1) begin n_fail++; $display("FAIL pre_resume actual=%0d required=1", Q); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_tab [4] = '{4'd2, 4'd1, 4'd0, 4'd15};
    logic         dir_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      UP = dir_tab[k];
      step();
      n_checks++;
      if (Q !== exp_tab[k]) begin
        n_fail++; $display("FAIL dir_change step=%0d actual=%0d required=%0d", k, Q, exp_tab[k]);
      end
    end
    n_checks++;
    if (OVF !== 1'b1) begin n_fail++; $display("FAIL dir_change_ovf actual=%b required=1", OVF); end
  endtask

`ifdef JK_CNT_MODN_EN
  task automatic test_modn();
    logic [W-1:0] exp_q;
    PRE = 1'b1; EN = 1'b0; LOAD = 1'b0; UP = 1'b1;
    step();
    PRE = 1'b0; EN = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_q = W'(k % 10);
      n_checks++;
      if (Q !== exp_q || TC !== (exp_q == 4'd9)) begin
        n_fail++; $display("FAIL modn_up step=%0d actual=q%0d tc%b required=q%0d tc%b",
                           k, Q, TC, exp_q, (exp_q == 4'd9));
      end
    end
    UP = 1'b0;
    step();
    n_checks++;
    if (Q !== 4'd9) begin n_fail++; $display("FAIL modn_down_wrap actual=%0d required=9", Q); end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
`ifdef JK_CNT_MODN_EN
    test_modn();
`else
    test_up_count();
    test_down_count();
    test_load_priority();
    test_hold();
    test_pre_priority();
    test_back_to_back();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
